// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings shared by the main controller, the ALU control decoder
// and the datapath.
//   - opcode map (IR[15:12])
//   - controller state enum (4-bit, also exported on the debug state port)
//   - ALUOp, pc_source and alu_src_b encodings
//   - decode_dispatch(): opcode -> state entered from DECODE
//     (S_TRAP marks an illegal opcode)
package cpu_pkg;

  localparam logic [3:0] OP_R0    = 4'b0000;
  localparam logic [3:0] OP_R1    = 4'b0001;
  localparam logic [3:0] OP_SHIFT = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0011;
  localparam logic [3:0] OP_SW    = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SLTI  = 4'b1011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_IFMT  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_TWO   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  function automatic state_t decode_dispatch(input logic [3:0] op);
    case (op)
      OP_R0, OP_R1:                        return S_R_EXEC;
      OP_SHIFT, OP_ADDI, OP_SUBI, OP_SLTI: return S_I_EXEC;
      OP_LW, OP_SW:                        return S_MEM_ADDR;
      OP_BEQ:                              return S_BRANCH;
      OP_J:                                return S_JUMP;
      default:                             return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_outdec.sv
// cpu_ctrl_outdec: pure combinational decoder from the controller state
// (plus opcode, zero, mem_ready) to the datapath strobes.
// Inputs : state (4-bit state encoding), opcode, zero, mem_ready
// Outputs: mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source,
//          alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
//          illegal, dispatch (state to enter from DECODE for this opcode)
// Build option: CPU_ILLEGAL_TRAP_EN drives illegal high while in TRAP;
// otherwise illegal is tied low.
module cpu_ctrl_outdec
  import cpu_pkg::*;
(
  input  logic [3:0] state,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] dispatch
);

  state_t st;
  assign st       = state_t'(state);
  assign dispatch = decode_dispatch(opcode);

`ifdef CPU_ILLEGAL_TRAP_EN
  assign illegal = (st == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (st)
      S_FETCH: begin
        // PC+2 is computed every fetch cycle; IR and PC only load once
        // the memory actually returns the instruction.
        mem_req   = 1'b1;
        alu_src_b = SRCB_TWO;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_BROFF;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_IFMT;
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        // ALUOut holds the branch target computed during DECODE.
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_source = PC_JUMP;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle main controller for the 16-bit CPU.
// Sequences fetch / decode / execute / memory / write-back, holds the
// memory request until mem_ready, and counts retired instructions.
// Inputs : clk, rst_n (sync, active-low), opcode, funct (pass-through,
//          not decoded here), zero, mem_ready
// Outputs: datapath strobes (see cpu_ctrl_outdec), illegal,
//          instr_count[CNT_W-1:0], state (debug)
// Build option: CPU_ILLEGAL_TRAP_EN -- illegal opcodes park the FSM in
// TRAP until reset; otherwise they retire as NOPs.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic [1:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  state_t           state_q;
  logic [CNT_W-1:0] count;
  logic [3:0]       dispatch;
  state_t           dispatch_st;
  logic             retire;
  logic             unused_funct;

  assign unused_funct = ^funct;
  assign dispatch_st  = state_t'(dispatch);
  assign state        = state_q;
  assign instr_count  = count;

  cpu_ctrl_outdec u_outdec (
    .state      (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .dispatch   (dispatch)
  );

  // An instruction retires on the cycle it leaves its last state.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR: retire = mem_ready;
`ifndef CPU_ILLEGAL_TRAP_EN
      S_DECODE: retire = (dispatch_st == S_TRAP);
`endif
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count   <= '0;
    end else begin
      if (retire) count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
`ifdef CPU_ILLEGAL_TRAP_EN
          state_q <= dispatch_st;
`else
          state_q <= (dispatch_st == S_TRAP) ? S_FETCH : dispatch_st;
`endif
        end
        S_MEM_ADDR: state_q <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        S_R_EXEC:   state_q <= S_R_WB;
        S_I_EXEC:   state_q <= S_I_WB;
        S_TRAP: begin
`ifdef CPU_ILLEGAL_TRAP_EN
          state_q <= S_TRAP;
`else
          state_q <= S_FETCH;
`endif
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [1:0]  funct;
  logic        zero;
  logic        mem_ready;

  logic        mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic        alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [15:0] instr_count;
  logic [3:0]  state;

  logic        mem_req4, mem_we4, i_or_d4, ir_write4, pc_write4;
  logic [1:0]  pc_source4, alu_src_b4, alu_op4;
  logic        alu_src_a4, reg_write4, reg_dst4, mem_to_reg4, illegal4;
  logic [3:0]  instr_count4;
  logic [3:0]  state4;

  always #5 clk = ~clk;

  cpu_control_fsm #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  cpu_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req4), .mem_we(mem_we4), .i_or_d(i_or_d4),
    .ir_write(ir_write4), .pc_write(pc_write4), .pc_source(pc_source4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
    .reg_write(reg_write4), .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4),
    .illegal(illegal4), .instr_count(instr_count4), .state(state4)
  );

  // Strobe bundle: {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source,
  //                 alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
  //                 mem_to_reg, illegal}
  logic [15:0] act_sb;
  assign act_sb = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source,
                   alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                   mem_to_reg, illegal};

  function automatic logic [15:0] sb(input logic mreq, input logic we,
      input logic iod, input logic irw, input logic pcw, input logic [1:0] pcs,
      input logic asa, input logic [1:0] asb, input logic [1:0] aop,
      input logic rw, input logic rd, input logic m2r, input logic ill);
    return {mreq, we, iod, irw, pcw, pcs, asa, asb, aop, rw, rd, m2r, ill};
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] sbx;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [15:0] sbx, input logic [15:0] cnt);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.sbx = sbx; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  logic [15:0] F_RDY, F_WAIT, DEC, MADR, MRD, MWB, MWR, REX, RWB, IEX, IWB, BR1, BR0, JMP;

  initial begin
    F_RDY  = sb(1,0,0,1,1,2'b00,0,2'b01,2'b00,0,0,0,0);
    F_WAIT = sb(1,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0);
    DEC    = sb(0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0);
    MADR   = sb(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
    MRD    = sb(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
    MWB    = sb(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0);
    MWR    = sb(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
    REX    = sb(0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0);
    RWB    = sb(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,0);
    IEX    = sb(0,0,0,0,0,2'b00,1,2'b10,2'b11,0,0,0,0);
    IWB    = sb(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,0);
    BR1    = sb(0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0);
    BR0    = sb(0,0,0,0,0,2'b01,1,2'b00,2'b01,0,0,0,0);
    JMP    = sb(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,0,0,0);

    // ADD (zero held high to expose any leak into pc_write)
    add(4'h1,1,1, 0,F_RDY,0); add(4'h1,1,1, 1,DEC,0);
    add(4'h1,1,1, 6,REX,0);   add(4'h1,1,1, 7,RWB,0);
    // ADDI
    add(4'h9,0,1, 0,F_RDY,1); add(4'h9,0,1, 1,DEC,1);
    add(4'h9,0,1, 8,IEX,1);   add(4'h9,0,1, 9,IWB,1);
    // LW with two wait cycles in MEM_RD
    add(4'h3,0,1, 0,F_RDY,2); add(4'h3,0,1, 1,DEC,2); add(4'h3,0,1, 2,MADR,2);
    add(4'h3,0,0, 3,MRD,2);   add(4'h3,0,0, 3,MRD,2); add(4'h3,0,1, 3,MRD,2);
    add(4'h3,0,1, 4,MWB,2);
    // SW
    add(4'h4,0,1, 0,F_RDY,3); add(4'h4,0,1, 1,DEC,3); add(4'h4,0,1, 2,MADR,3);
    add(4'h4,0,1, 5,MWR,3);
    // BEQ taken / not taken
    add(4'h5,1,1, 0,F_RDY,4); add(4'h5,1,1, 1,DEC,4); add(4'h5,1,1, 10,BR1,4);
    add(4'h5,0,1, 0,F_RDY,5); add(4'h5,0,1, 1,DEC,5); add(4'h5,0,1, 10,BR0,5);
    // J
    add(4'h6,1,1, 0,F_RDY,6); add(4'h6,1,1, 1,DEC,6); add(4'h6,1,1, 11,JMP,6);
    // R-type 0000 with one fetch wait
    add(4'h0,0,0, 0,F_WAIT,7); add(4'h0,0,1, 0,F_RDY,7); add(4'h0,0,1, 1,DEC,7);
    add(4'h0,0,1, 6,REX,7);    add(4'h0,0,1, 7,RWB,7);

    // Reset state
    rst_n = 1'b0; opcode = 4'h0; funct = 2'b10; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_count", {16'd0, instr_count}, 32'd0);
    chk("reset_strobes", {16'd0, act_sb}, {16'd0, F_WAIT});
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
      chk($sformatf("vec%0d_strobes", i), {16'd0, act_sb}, {16'd0, vecs[i].sbx});
      chk($sformatf("vec%0d_count", i), {16'd0, instr_count}, {16'd0, vecs[i].cnt});
    end

    // Reset in the middle of a stalled MEM_RD
    @(negedge clk); opcode = 4'h3; zero = 1'b0; mem_ready = 1'b1; #1;
    chk("mid_fetch_state", {28'd0, state}, 32'd0);
    chk("mid_count8", {16'd0, instr_count}, 32'd8);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("mid_memrd_state", {28'd0, state}, 32'd3);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_state", {28'd0, state}, 32'd0);
    chk("rst_mid_count", {16'd0, instr_count}, 32'd0);
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd1);
    chk("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_count4", {28'd0, instr_count4}, 32'd0);

    // 17 back-to-back jumps: the 4-bit counter wraps 15 -> 0 -> 1
    rst_n = 1'b1; opcode = 4'h6; mem_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("wrap_count4_%0d", k), {28'd0, instr_count4}, k % 16);
      chk($sformatf("wrap_state_%0d", k), {28'd0, state}, 32'd0);
    end
    chk("wrap_count16", {16'd0, instr_count}, 32'd17);

    // Illegal opcode 1111
    @(negedge clk); opcode = 4'hF; #1;
    chk("ill_decode_state", {28'd0, state}, 32'd1);
    chk("ill_decode_strobes", {16'd0, act_sb}, {16'd0, DEC});
`ifdef CPU_ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk($sformatf("trap_state_%0d", k), {28'd0, state}, 32'd12);
      chk($sformatf("trap_strobes_%0d", k), {16'd0, act_sb}, 32'd1);
      chk($sformatf("trap_count_%0d", k), {16'd0, instr_count}, 32'd17);
    end
`else
    @(negedge clk); #1;
    chk("nop_state", {28'd0, state}, 32'd0);
    chk("nop_count", {16'd0, instr_count}, 32'd18);
    chk("nop_illegal", {31'd0, illegal}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
